// File: rtl/adder_tree_pipe_pkg.sv
// Shared helpers for the pipelined adder tree.
//   log2i      : ceiling log2 of a positive integer (stage count).
//   bus_off    : bit offset of stage k's partial sums in the top's flat bus.
//   reduce_sum : reduces an exact sum to the output width, either saturating
//                or passing through so the caller keeps the low bits (wrap).
//                Returns {sat_flag, value[63:0]}.
package adder_tree_pipe_pkg;

    function automatic int log2i(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Stage j holds (n_in >> j) partial sums of (data_w + j) bits each;
    // stage 0 is the raw operand vector.
    function automatic int bus_off(input int k, input int n_in, input int data_w);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) begin
            o += (n_in >> j) * (data_w + j);
        end
        return o;
    endfunction

    function automatic logic [64:0] reduce_sum(input logic signed [63:0] sum,
                                               input int out_w,
                                               input int full_w,
                                               input bit sat_en);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        // Exact width, or wrap mode: the caller simply keeps the low bits.
        if (out_w >= full_w || !sat_en) return {1'b0, sum};
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (sum > hi) return {1'b1, hi};
        if (sum < lo) return {1'b1, lo};
        return {1'b0, sum};
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered pairwise-add stage of the adder tree.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance; 0 holds every register
//   in_valid   : valid bit from the previous stage
//   in_data    : 2*PAIRS signed operands of IN_W bits
//   out_valid  : registered valid bit
//   out_data   : PAIRS reduced sums of OUT_W bits (OUT_W = IN_W+1 is exact)
//   out_sat    : any sum of this vector was clamped
module adder_tree_stage
    import adder_tree_pipe_pkg::*;
#(
    parameter int IN_W   = 7,
    parameter int PAIRS  = 4,
    parameter int OUT_W  = IN_W + 1,
    parameter bit SAT_EN = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [2*PAIRS*IN_W-1:0] in_data,
    output logic                    out_valid,
    output logic [PAIRS*OUT_W-1:0]  out_data,
    output logic                    out_sat
);

    localparam int SUM_W = IN_W + 1;

    logic signed [SUM_W-1:0] op_a;
    logic signed [SUM_W-1:0] op_b;
    logic signed [SUM_W-1:0] sum;
    logic signed [63:0]      sum64;
    logic [64:0]             red;
    logic [PAIRS*OUT_W-1:0]  nxt_data;
    logic                    nxt_sat;
    logic                    unused_hi;

    always_comb begin
        op_a      = '0;
        op_b      = '0;
        sum       = '0;
        sum64     = '0;
        red       = '0;
        nxt_data  = '0;
        nxt_sat   = 1'b0;
        unused_hi = 1'b0;
        for (int j = 0; j < PAIRS; j++) begin
            // One extra bit per stage means the add can never overflow.
            op_a  = {in_data[(2*j+1)*IN_W-1], in_data[2*j*IN_W +: IN_W]};
            op_b  = {in_data[(2*j+2)*IN_W-1], in_data[(2*j+1)*IN_W +: IN_W]};
            sum   = op_a + op_b;
            sum64 = {{(64-SUM_W){sum[SUM_W-1]}}, sum};
            red   = reduce_sum(sum64, OUT_W, SUM_W, SAT_EN);
            nxt_data[j*OUT_W +: OUT_W] = red[OUT_W-1:0];
            nxt_sat   = nxt_sat | red[64];
            unused_hi = unused_hi ^ (^red[63:OUT_W]);
        end
    end

    // Valid always advances with en; data only loads under a valid vector,
    // so bubbles leave the previous result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= nxt_data;
                out_sat  <= nxt_sat;
            end
        end
    end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: sums N_IN operands in log2(N_IN) registered
// stages. The final stage reduces to OUT_W bits (saturate or wrap) before
// its register, so reduction costs no extra latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : pipeline advance; 0 stalls every stage
//   in_valid   : in_data holds a vector to accept
//   in_data    : N_IN packed signed operands, operand i at [i*DATA_W +: DATA_W]
//   out_valid  : out_data/out_sat hold a result
//   out_data   : signed sum, OUT_W bits
//   out_sat    : result was clamped
module adder_tree_pipe
    import adder_tree_pipe_pkg::*;
#(
    parameter int DATA_W = 7,
    parameter int N_IN   = 8,
    parameter int OUT_W  = DATA_W + log2i(N_IN),
    parameter bit SAT_EN = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [N_IN*DATA_W-1:0] in_data,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_sat
);

    localparam int L     = log2i(N_IN);
    localparam int BUS_W = bus_off(L, N_IN, DATA_W);

    // Flat bus holding the operands followed by stages 1..L-1; the last
    // stage drives the outputs directly.
    logic [BUS_W-1:0] bus;
    logic [L:0]       vld;
    logic [L:1]       stage_sat;
    logic             unused_sat;

    assign bus[N_IN*DATA_W-1:0] = in_data;
    assign vld[0]               = in_valid;

    for (genvar k = 1; k <= L; k++) begin : g_stage
        localparam int IW     = DATA_W + k - 1;
        localparam int PAIRS  = N_IN >> k;
        localparam int IN_OFF = bus_off(k - 1, N_IN, DATA_W);
        if (k < L) begin : g_mid
            localparam int OO = bus_off(k, N_IN, DATA_W);
            adder_tree_stage #(
                .IN_W  (IW),
                .PAIRS (PAIRS),
                .OUT_W (IW + 1),
                .SAT_EN(1'b0)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en),
                .in_valid (vld[k-1]),
                .in_data  (bus[IN_OFF +: 2*PAIRS*IW]),
                .out_valid(vld[k]),
                .out_data (bus[OO +: PAIRS*(IW+1)]),
                .out_sat  (stage_sat[k])
            );
        end else begin : g_last
            adder_tree_stage #(
                .IN_W  (IW),
                .PAIRS (PAIRS),
                .OUT_W (OUT_W),
                .SAT_EN(SAT_EN)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en),
                .in_valid (vld[k-1]),
                .in_data  (bus[IN_OFF +: 2*PAIRS*IW]),
                .out_valid(vld[k]),
                .out_data (out_data),
                .out_sat  (stage_sat[k])
            );
        end
    end

    assign out_valid  = vld[L];
    assign out_sat    = stage_sat[L];
    // Internal stages never clamp; their flags are tied off here.
    assign unused_sat = ^stage_sat;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: four instances share one stimulus stream
// (default exact, OUT_W=8 saturating, OUT_W=8 wrapping, N_IN=2 single stage).
// A reference model queues each accepted vector's arithmetic sum with the
// advance count at which it must be visible on the outputs.
module tb_adder_tree_pipe;

    localparam int DW = 7;
    localparam int N  = 8;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          in_valid = 1'b0;
    logic [N*DW-1:0] in_data = '0;

    logic       v_a, s_a, v_s, s_s, v_w, s_w, v_2, s_2;
    logic [9:0] d_a;
    logic [7:0] d_s, d_w, d_2;

    always #5 clk = ~clk;

    adder_tree_pipe u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
        .out_valid(v_a), .out_data(d_a), .out_sat(s_a));

    adder_tree_pipe #(.OUT_W(8), .SAT_EN(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
        .out_valid(v_s), .out_data(d_s), .out_sat(s_s));

    adder_tree_pipe #(.OUT_W(8), .SAT_EN(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
        .out_valid(v_w), .out_data(d_w), .out_sat(s_w));

    adder_tree_pipe #(.N_IN(2)) u_n2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data[2*DW-1:0]),
        .out_valid(v_2), .out_data(d_2), .out_sat(s_2));

    int total  = 0;
    int passed = 0;
    int adv    = 0;
    int sum3_q[$];
    int due3_q[$];
    int sum1_q[$];
    int due1_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int vec_sum(input logic [N*DW-1:0] d, input int n);
        int s;
        int o;
        s = 0;
        for (int i = 0; i < n; i++) begin
            o = int'(d[i*DW +: DW]);
            if (o >= 64) o -= 128;
            s += o;
        end
        return s;
    endfunction

    function automatic logic [N*DW-1:0] fill(input int v);
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = 7'(v);
        return r;
    endfunction

    task automatic check_outputs();
        bit         e3, e1;
        int         s, es;
        logic [9:0] x10;
        logic [7:0] x8;
        e3 = (due3_q.size() > 0) && (due3_q[0] == adv);
        e1 = (due1_q.size() > 0) && (due1_q[0] == adv);
        chk("valid_def",  {31'b0, v_a}, {31'b0, e3});
        chk("valid_sat",  {31'b0, v_s}, {31'b0, e3});
        chk("valid_wrap", {31'b0, v_w}, {31'b0, e3});
        chk("valid_n2",   {31'b0, v_2}, {31'b0, e1});
        if (e3) begin
            s   = sum3_q[0];
            x10 = 10'(s);
            chk("data_def", {22'b0, d_a}, {22'b0, x10});
            chk("sat_def",  {31'b0, s_a}, 32'd0);
            es  = (s > 127) ? 127 : ((s < -128) ? -128 : s);
            x8  = 8'(es);
            chk("data_sat", {24'b0, d_s}, {24'b0, x8});
            chk("flag_sat", {31'b0, s_s}, {31'b0, (s > 127 || s < -128)});
            x8  = 8'(s);
            chk("data_wrap", {24'b0, d_w}, {24'b0, x8});
            chk("flag_wrap", {31'b0, s_w}, 32'd0);
        end
        if (e1) begin
            x8 = 8'(sum1_q[0]);
            chk("data_n2", {24'b0, d_2}, {24'b0, x8});
            chk("flag_n2", {31'b0, s_2}, 32'd0);
        end
    endtask

    // Drive one cycle, update the model at the edge, check 1 time unit later.
    task automatic cycle(input bit e, input bit v, input logic [N*DW-1:0] d);
        en       = e;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        if (rst_n && e) begin
            adv++;
            while (due3_q.size() > 0 && due3_q[0] < adv) begin
                void'(due3_q.pop_front());
                void'(sum3_q.pop_front());
            end
            while (due1_q.size() > 0 && due1_q[0] < adv) begin
                void'(due1_q.pop_front());
                void'(sum1_q.pop_front());
            end
            if (v) begin
                sum3_q.push_back(vec_sum(d, N));
                due3_q.push_back(adv + L - 1);
                sum1_q.push_back(vec_sum(d, 2));
                due1_q.push_back(adv);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic directed(input string tag, input logic [N*DW-1:0] d,
                            input logic [9:0] e_def, input logic [7:0] e_sat,
                            input logic e_flag, input logic [7:0] e_wrap);
        cycle(1'b1, 1'b1, d);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        chk({tag, "_valid"}, {31'b0, v_a}, 32'd1);
        chk({tag, "_def"},   {22'b0, d_a}, {22'b0, e_def});
        chk({tag, "_sat"},   {24'b0, d_s}, {24'b0, e_sat});
        chk({tag, "_flag"},  {31'b0, s_s}, {31'b0, e_flag});
        chk({tag, "_wrap"},  {24'b0, d_w}, {24'b0, e_wrap});
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
    endtask

    function automatic logic [N*DW-1:0] rand_vec();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[N*DW-1:0];
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_v_def"},  {31'b0, v_a}, 32'd0);
        chk({tag, "_v_sat"},  {31'b0, v_s}, 32'd0);
        chk({tag, "_v_wrap"}, {31'b0, v_w}, 32'd0);
        chk({tag, "_v_n2"},   {31'b0, v_2}, 32'd0);
        chk({tag, "_d_def"},  {22'b0, d_a}, 32'd0);
        chk({tag, "_d_sat"},  {24'b0, d_s}, 32'd0);
        chk({tag, "_s_sat"},  {31'b0, s_s}, 32'd0);
        chk({tag, "_d_n2"},   {24'b0, d_2}, 32'd0);
    endtask

    initial begin
        logic [N*DW-1:0] alt;
        alt = '0;
        for (int i = 0; i < N; i++) begin
            alt[i*DW +: DW] = 7'((i % 2 == 0) ? (i + 1) : -(i + 1));
        end

        // Reset state
        #1;
        check_reset_state("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed values
        directed("all63",  fill(63),  10'd504,  8'd127,  1'b1, 8'hF8);
        directed("allm64", fill(-64), 10'h200,  8'h80,   1'b1, 8'h00);
        directed("alt",    alt,       10'h3FC,  8'hFC,   1'b0, 8'hFC);
        directed("all10",  fill(10),  10'd80,   8'd80,   1'b0, 8'd80);

        // A, B, two stalled cycles (inputs ignored), C
        cycle(1'b1, 1'b1, rand_vec());
        cycle(1'b1, 1'b1, rand_vec());
        cycle(1'b0, 1'b1, rand_vec());
        cycle(1'b0, 1'b1, rand_vec());
        cycle(1'b1, 1'b1, rand_vec());
        repeat (5) cycle(1'b1, 1'b0, '0);

        // Random traffic with random stalls and bubbles
        repeat (80) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rand_vec());
        end
        repeat (5) cycle(1'b1, 1'b0, '0);

        // Reset while two vectors are in flight
        cycle(1'b1, 1'b1, rand_vec());
        cycle(1'b1, 1'b1, rand_vec());
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        sum3_q.delete();
        due3_q.delete();
        sum1_q.delete();
        due1_q.delete();
        cycle(1'b1, 1'b1, rand_vec());
        rst_n = 1'b1;
        repeat (5) cycle(1'b1, 1'b0, '0);

        // Traffic after release
        repeat (40) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rand_vec());
        end
        repeat (5) cycle(1'b1, 1'b0, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adder_tree_pipe.md
ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

Interface
REQ-001 Parameter DATA_W, default 7, width of each signed two's-complement operand; legal range 2..32.
REQ-002 Parameter N_IN, default 8, operand count; power of two, 2..64; L = log2(N_IN) is the number of pipeline stages.
REQ-003 Parameter OUT_W, default DATA_W+L, output width; legal range 2..DATA_W+L.
REQ-004 Parameter SAT_EN, default 0; 1 = saturate when OUT_W < DATA_W+L, 0 = wrap to the low OUT_W bits.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  pipeline advance; 0 = every stage holds (stall).
REQ-008 in_valid  input  1  in_data carries a valid operand vector this cycle.
REQ-009 in_data  input  N_IN*DATA_W  packed operands; operand i at bits [i*DATA_W +: DATA_W], signed.
REQ-010 out_valid  output  1  out_data/out_sat carry a valid result.
REQ-011 out_data  output  OUT_W  signed sum of one operand vector.
REQ-012 out_sat  output  1  out_data was clamped for this result (always 0 when SAT_EN=0 or OUT_W = DATA_W+L).

Function
REQ-013 Stage k (1..L) holds N_IN/2^k registered partial sums, each DATA_W+k bits wide, plus one valid bit.
REQ-014 Each stage adds adjacent pairs (2j, 2j+1) of the previous stage, sign-extending both by one bit; no overflow is possible inside the tree.
REQ-015 With en=1 every cycle, a vector accepted at edge t appears on out_data with out_valid=1 after edge t+L-1 (latency L cycles from the accepting edge).
REQ-016 A vector is accepted on a rising edge where en=1 and in_valid=1; in_valid=0 with en=1 injects a bubble (valid bit 0) that propagates with the same latency.
REQ-017 When en=0 all data and valid registers hold; in_data/in_valid are ignored that cycle; no result is lost or duplicated.
REQ-018 Partial-sum registers load only when the incoming valid bit is 1 (data held under bubbles); valid bits always load when en=1.
REQ-019 Output reduction is applied to the stage-L input before registering, so out_data/out_sat add no latency.
REQ-020 OUT_W = DATA_W+L: out_data is the exact sum.
REQ-021 OUT_W < DATA_W+L, SAT_EN=1: sums above 2^(OUT_W-1)-1 clamp to that value, sums below -2^(OUT_W-1) clamp to that value, out_sat=1 in both cases, else 0.
REQ-022 OUT_W < DATA_W+L, SAT_EN=0: out_data is the low OUT_W bits of the exact sum; out_sat=0.
REQ-023 N_IN=2 is a single-stage tree with latency 1.

Reset
REQ-024 rst_n low clears all valid bits, all partial sums, out_data, out_sat immediately, independent of clk.
REQ-025 Reset asserted mid-operation discards all in-flight vectors; none appear after release.
REQ-026 First acceptance after release occurs on the first rising edge with rst_n=1, en=1, in_valid=1.

Structure
REQ-027 A shared package holds the log2 helper function and the saturation/wrap reduction function; no typedefs are required.
REQ-028 One sub-module, adder_tree_stage, parametrised by input width and pair count, implements one registered pairwise-add stage with its valid bit and enable; the top instantiates L of them via generate.
REQ-029 Adders are behavioural signed additions; no hand-instantiated full-adder cells.

Verification
REQ-030 Default params, all operands 63, en=1 -> out_data=504, out_valid exactly 3 cycles after accept.
REQ-031 Default params, all operands -64 -> out_data=-512; operands 0..7 as values 1,-2,3,-4,5,-6,7,-8 -> -4.
REQ-032 OUT_W=8, SAT_EN=1: all 63 -> 127, out_sat=1; all -64 -> -128, out_sat=1; all 10 -> 80, out_sat=0.
REQ-033 OUT_W=8, SAT_EN=0: all 63 -> out_data = low 8 bits of 504 = -8, out_sat=0.
REQ-034 Back-to-back vectors A,B,C with en dropped for 2 cycles after B's accept -> outputs A,B,C in order, each once, B and C delayed by 2 cycles.
REQ-035 rst_n pulsed low while 2 vectors in flight -> out_valid=0 immediately and no stale result after release.
